aes_text_loader: RTL and testbench
==================================

Name: aes_text_loader

Overview:
- Input staging block directly upstream of aes_cipher_top.
- Accepts plaintext as a valid/ready stream of 32-bit words and assembles each group of four words into a 128-bit block.
- Drives text_in, key and a single-cycle ld pulse into the cipher core, then tracks its busy/done cycle.
- One staging buffer lets the next block be filled while the core is still processing the current one.

Parameters:
- WORD_W, 32, input stream word width; must divide BLOCK_W.
- BLOCK_W, 128, cipher block width.
- CNT_W, 16, width of the issued-block counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  input word valid.
- s_ready  out  1  loader can accept a word.
- s_data  in  WORD_W  input word; the first word of a block maps to text_in[127:96].
- cfg_key  in  BLOCK_W  key, sampled on the ld cycle.
- ld  out  1  one-cycle load strobe to the cipher core.
- text_in  out  BLOCK_W  block presented to the core; held stable between ld pulses.
- key  out  BLOCK_W  key presented to the core; held stable between ld pulses.
- done  in  1  cipher completion pulse.
- busy  out  1  a block is in flight in the core.
- blk_cnt  out  CNT_W  number of ld pulses issued; wraps modulo 2^CNT_W.
- err_done  out  1  sticky: done was seen while busy=0.

Behaviour:
- Reset (rst=1 at a clock edge) clears all state. Values after reset:
  - s_ready=1
  - ld=0, busy=0, err_done=0
  - text_in=0, key=0, blk_cnt=0
  - word counter wcnt=0, staging buffer empty (full=0)
- Reset mid-block discards any partial or full staged block. Reset while busy drops busy; a later done is then ignored and does not set err_done.
- Word accept:
  - A word is accepted when s_valid & s_ready.
  - s_ready = !full, combinational from registered state.
  - Accepted word k (k = wcnt, 0..3) is written to asm[BLOCK_W-1-k*WORD_W -: WORD_W].
  - wcnt increments on each accept. On the 4th accept, wcnt wraps to 0 and full<=1 on that edge.
  - s_data is ignored when s_valid=0.
- Issue:
  - Condition: full=1 and busy=0 at a clock edge.
  - Registered effects on that edge: ld<=1, text_in<=asm, key<=cfg_key, busy<=1, full<=0, blk_cnt<=blk_cnt+1.
  - ld is high for exactly one cycle.
  - Minimum latency from the accept of the 4th word to ld high is 2 cycles: the accept edge sets full, the next edge raises ld.
- Completion:
  - done=1 while busy=1 clears busy on that edge.
  - Issue requires busy=0 as registered, so the earliest next ld is the edge after the done edge. ld and done never coincide on a busy transition.
  - done=1 while busy=0 sets err_done and has no other effect. err_done clears only on reset.
- Overlap: while busy=1 the stream keeps filling asm. Once full=1, s_ready drops until issue. The buffer holds at most one staged block.
- text_in and key change only on issue edges.
- Word ordering is MSB-first, with no byte swapping.
- FSM view, derived from full/busy:
  - IDLE (!full, !busy) → FILL on an accept.
  - FILL → STAGED on the 4th accept.
  - STAGED → ISSUE (one cycle, ld=1) when !busy.
  - ISSUE → RUN.
  - RUN → IDLE on done, or RUN+FILL if words are accepted during the run.

Test Plan:
- Reset, then send words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF back-to-back with cfg_key=0x000102...0F → ld high exactly 2 cycles after the 4th accept; text_in=0x00112233_44556677_8899AABB_CCDDEEFF; key=0x000102...0F; busy=1; blk_cnt=1.
- With the first block busy, send 4 more words, then hold s_valid → s_ready=0 after the 4th accept; no ld until done; pulse done → ld on the next edge; blk_cnt=2.
- s_valid toggling 1,0,1,0,... over 8 cycles → exactly 4 accepts, one block issued, word order preserved.
- done pulse with busy=0 → err_done=1 and stays high; ld, text_in and blk_cnt unchanged.
- Assert rst after 2 words accepted, then send 4 new words → only the new words appear in text_in; err_done=0; blk_cnt=1.
- Preload blk_cnt to 0xFFFF (force) and issue one block → blk_cnt=0x0000 and ld behaviour is unaffected.

Source files
------------

// File: rtl/aes_text_loader_if.sv
// Plaintext word stream into the AES text loader.
interface aes_text_loader_if #(
    parameter int WORD_W = 32
) ();
    logic              s_valid;
    logic              s_ready;
    logic [WORD_W-1:0] s_data;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );
endinterface

// File: rtl/aes_text_loader.sv
// Staging block in front of aes_cipher_top. It packs stream words MSB-first
// into a 128-bit block, then launches the block into the core with a one-cycle
// ld strobe. It follows the core's busy/done handshake. A single staging
// buffer lets the next block fill up while the core is working on the current one.
//
// Core-side FSM:
//   state   | meaning
//   C_IDLE  | no block in the core; a staged block is issued from here
//   C_ISSUE | ld cycle, text_in/key just loaded, core busy
//   C_RUN   | block in flight, waiting for done
module aes_text_loader #(
    parameter int WORD_W  = 32,
    parameter int BLOCK_W = 128,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    aes_text_loader_if.slave   s_if,
    input  logic [BLOCK_W-1:0] cfg_key,
    output logic               ld,
    output logic [BLOCK_W-1:0] text_in,
    output logic [BLOCK_W-1:0] key,
    input  logic               done,
    output logic               busy,
    output logic [CNT_W-1:0]   blk_cnt,
    output logic               err_done
);
    localparam int NW     = BLOCK_W / WORD_W;
    localparam int WCNT_W = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic [1:0] {
        C_IDLE  = 2'd0,
        C_ISSUE = 2'd1,
        C_RUN   = 2'd2
    } core_state_e;

    core_state_e        state_q, state_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic               full_q, full_d;
    logic [BLOCK_W-1:0] asm_q, asm_d;
    logic [BLOCK_W-1:0] text_q, text_d;
    logic [BLOCK_W-1:0] key_q, key_d;
    logic [CNT_W-1:0]   blk_cnt_q, blk_cnt_d;
    logic               err_q, err_d;
    // Set when reset cut off a block in flight, so the core's late done is
    // absorbed instead of being flagged as spurious.
    logic               drop_q, drop_d;
    logic               accept;
    logic               issue;

    assign s_if.s_ready = !full_q;
    assign accept       = s_if.s_valid && !full_q;
    assign issue        = full_q && (state_q == C_IDLE);

    assign ld       = (state_q == C_ISSUE);
    assign busy     = (state_q != C_IDLE);
    assign text_in  = text_q;
    assign key      = key_q;
    assign blk_cnt  = blk_cnt_q;
    assign err_done = err_q;

    // Word assembly into the staging buffer, MSB-first.
    always_comb begin
        wcnt_d = wcnt_q;
        full_d = full_q;
        asm_d  = asm_q;
        if (accept) begin
            for (int k = 0; k < NW; k++) begin
                if (wcnt_q == WCNT_W'(k)) begin
                    asm_d[BLOCK_W-1-k*WORD_W -: WORD_W] = s_if.s_data;
                end
            end
            if (wcnt_q == WCNT_W'(NW - 1)) begin
                wcnt_d = '0;
                full_d = 1'b1;
            end else begin
                wcnt_d = wcnt_q + 1'b1;
            end
        end else if (issue) begin
            full_d = 1'b0;
        end
    end

    // Core-side next state: issue, completion tracking and spurious-done flag.
    always_comb begin
        state_d   = state_q;
        text_d    = text_q;
        key_d     = key_q;
        blk_cnt_d = blk_cnt_q;
        err_d     = err_q;
        drop_d    = drop_q;
        case (state_q)
            C_IDLE: begin
                if (done) begin
                    if (drop_q) begin
                        drop_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (issue) begin
                    state_d   = C_ISSUE;
                    text_d    = asm_q;
                    key_d     = cfg_key;
                    blk_cnt_d = blk_cnt_q + 1'b1;
                    drop_d    = 1'b0;
                end
            end
            C_ISSUE, C_RUN: begin
                state_d = done ? C_IDLE : C_RUN;
            end
            default: begin
                state_d = C_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= C_IDLE;
            wcnt_q    <= '0;
            full_q    <= 1'b0;
            asm_q     <= '0;
            text_q    <= '0;
            key_q     <= '0;
            blk_cnt_q <= '0;
            err_q     <= 1'b0;
            drop_q    <= (state_q != C_IDLE);
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            full_q    <= full_d;
            asm_q     <= asm_d;
            text_q    <= text_d;
            key_q     <= key_d;
            blk_cnt_q <= blk_cnt_d;
            err_q     <= err_d;
            drop_q    <= drop_d;
        end
    end
endmodule

// File: tb/tb_aes_text_loader.sv
// Self-checking bench for aes_text_loader: directed scenarios followed by a
// random phase, all compared against a queue-based reference model.
module tb_aes_text_loader;
    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] cfg_key;
    logic         ld;
    logic [127:0] text_in;
    logic [127:0] key;
    logic         done;
    logic         busy;
    logic [15:0]  blk_cnt;
    logic         err_done;

    aes_text_loader_if #(.WORD_W(32)) bus ();

    aes_text_loader #(.WORD_W(32), .BLOCK_W(128), .CNT_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_if     (bus),
        .cfg_key  (cfg_key),
        .ld       (ld),
        .text_in  (text_in),
        .key      (key),
        .done     (done),
        .busy     (busy),
        .blk_cnt  (blk_cnt),
        .err_done (err_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: words waiting to form a block, blocks waiting for issue,
    // and the values the loader should be presenting to the core.
    logic [31:0]  words[$];
    logic [127:0] staged[$];
    logic [127:0] m_text, m_key;
    logic [15:0]  m_cnt;
    bit           m_busy, m_err, m_drop;
    int           n_ld;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle starting and ending at a falling edge.
    task automatic cycle(input bit v, input logic [31:0] d, input bit dn);
        bit           exp_ready, exp_ld, prev_busy;
        logic [127:0] blk;
        exp_ready     = (staged.size() == 0);
        exp_ld        = (staged.size() > 0) && !m_busy;
        prev_busy     = m_busy;
        bus.s_valid   = v;
        bus.s_data    = d;
        done          = dn;
        chk("s_ready", {127'd0, bus.s_ready}, {127'd0, exp_ready});
        @(negedge clk);
        if (dn) begin
            if (prev_busy)   m_busy = 1'b0;
            else if (m_drop) m_drop = 1'b0;
            else             m_err  = 1'b1;
        end
        if (exp_ld) begin
            blk    = staged.pop_front();
            m_text = blk;
            m_key  = cfg_key;
            m_cnt  = m_cnt + 16'd1;
            m_busy = 1'b1;
            m_drop = 1'b0;
        end
        if (v && exp_ready) begin
            words.push_back(d);
            if (words.size() == 4) begin
                staged.push_back({words[0], words[1], words[2], words[3]});
                words.delete();
            end
        end
        if (ld === 1'b1) n_ld++;
        chk("ld", {127'd0, ld}, {127'd0, exp_ld});
        chk("text_in", text_in, m_text);
        chk("key", key, m_key);
        chk("busy", {127'd0, busy}, {127'd0, m_busy});
        chk("blk_cnt", {112'd0, blk_cnt}, {112'd0, m_cnt});
        chk("err_done", {127'd0, err_done}, {127'd0, m_err});
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        done        = 1'b0;
        @(negedge clk);
        rst    = 1'b0;
        m_drop = m_busy;
        m_busy = 1'b0;
        m_err  = 1'b0;
        m_text = '0;
        m_key  = '0;
        m_cnt  = '0;
        words.delete();
        staged.delete();
    endtask

    task automatic send4(input logic [31:0] a, b, c, d);
        cycle(1'b1, a, 1'b0);
        cycle(1'b1, b, 1'b0);
        cycle(1'b1, c, 1'b0);
        cycle(1'b1, d, 1'b0);
    endtask

    initial begin
        int           ld0;
        logic [127:0] t_hold;
        logic [31:0]  w[4];
        bit           v, dn;

        rst         = 1'b1;
        cfg_key     = 128'h000102030405060708090A0B0C0D0E0F;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        done        = 1'b0;
        m_busy      = 1'b0;
        m_drop      = 1'b0;
        n_ld        = 0;
        @(negedge clk);
        do_reset();
        m_drop = 1'b0;

        // Reset values
        chk("rst_s_ready", {127'd0, bus.s_ready}, 128'd1);
        chk("rst_ld", {127'd0, ld}, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_err", {127'd0, err_done}, 128'd0);
        chk("rst_text", text_in, 128'd0);
        chk("rst_key", key, 128'd0);
        chk("rst_cnt", {112'd0, blk_cnt}, 128'd0);

        // First block, back-to-back words; ld on the edge after the 4th accept
        send4(32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF);
        chk("b1_no_ld_yet", {127'd0, ld}, 128'd0);
        cycle(1'b0, 32'h0, 1'b0);
        chk("b1_ld", {127'd0, ld}, 128'd1);
        chk("b1_text", text_in, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        chk("b1_key", key, 128'h000102030405060708090A0B0C0D0E0F);
        chk("b1_busy", {127'd0, busy}, 128'd1);
        chk("b1_cnt", {112'd0, blk_cnt}, 128'd1);

        // Overlap: fill the staging buffer while block 1 is in flight
        for (int i = 0; i < 4; i++) w[i] = $urandom;
        send4(w[0], w[1], w[2], w[3]);
        for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, 1'b0);
        chk("ovl_ready_low", {127'd0, bus.s_ready}, 128'd0);
        chk("ovl_cnt_hold", {112'd0, blk_cnt}, 128'd1);
        cycle(1'b0, 32'h0, 1'b1);
        chk("ovl_busy_cleared", {127'd0, busy}, 128'd0);
        cycle(1'b0, 32'h0, 1'b0);
        chk("ovl_ld", {127'd0, ld}, 128'd1);
        chk("ovl_text", text_in, {w[0], w[1], w[2], w[3]});
        chk("ovl_cnt", {112'd0, blk_cnt}, 128'd2);
        cycle(1'b0, 32'h0, 1'b1);

        // Toggling valid: four accepts in eight cycles, one block
        ld0 = n_ld;
        for (int i = 0; i < 4; i++) w[i] = $urandom;
        for (int i = 0; i < 8; i++) cycle(((i % 2) == 0), (i % 2) == 0 ? w[i/2] : 32'hDEAD_BEEF, 1'b0);
        cycle(1'b0, 32'h0, 1'b0);
        chk("tog_ld_count", n_ld - ld0, 1);
        chk("tog_text", text_in, {w[0], w[1], w[2], w[3]});
        cycle(1'b0, 32'h0, 1'b1);

        // Spurious done while idle
        t_hold = text_in;
        cycle(1'b0, 32'h0, 1'b1);
        chk("sp_err", {127'd0, err_done}, 128'd1);
        chk("sp_text", text_in, t_hold);
        chk("sp_cnt", {112'd0, blk_cnt}, 128'd3);
        cycle(1'b0, 32'h0, 1'b0);
        chk("sp_err_sticky", {127'd0, err_done}, 128'd1);

        // Reset discards a partial block
        cycle(1'b1, 32'hAAAA_0000, 1'b0);
        cycle(1'b1, 32'hAAAA_1111, 1'b0);
        do_reset();
        send4(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        cycle(1'b0, 32'h0, 1'b0);
        chk("rp_text", text_in, 128'h11111111_22222222_33333333_44444444);
        chk("rp_err", {127'd0, err_done}, 128'd0);
        chk("rp_cnt", {112'd0, blk_cnt}, 128'd1);

        // Reset while busy: the late done is absorbed
        do_reset();
        cycle(1'b0, 32'h0, 1'b1);
        chk("rb_err", {127'd0, err_done}, 128'd0);
        cycle(1'b0, 32'h0, 1'b0);

        // Counter wrap from 0xFFFF
        force dut.blk_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.blk_cnt_q;
        m_cnt = 16'hFFFF;
        cycle(1'b0, 32'h0, 1'b0);
        chk("wrap_pre", {112'd0, blk_cnt}, 128'h0FFFF);
        cfg_key = {$urandom, $urandom, $urandom, $urandom};
        send4(32'h0F0F0F0F, 32'hF0F0F0F0, 32'h12345678, 32'h9ABCDEF0);
        cycle(1'b0, 32'h0, 1'b0);
        chk("wrap_ld", {127'd0, ld}, 128'd1);
        chk("wrap_cnt", {112'd0, blk_cnt}, 128'd0);
        cycle(1'b0, 32'h0, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) cfg_key = {$urandom, $urandom, $urandom, $urandom};
            v  = ($urandom_range(0, 2) != 0);
            dn = m_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 30) == 0);
            cycle(v, $urandom, dn);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
